// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage MIPS hazard/sequencing controller.
//   drain_state_e : syscall drain FSM encoding (ST_RUN/ST_DRAIN/ST_EXEC/ST_HALT)
//   FWD_*         : EX operand forwarding select encoding
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } drain_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF        = 32;
    localparam int unsigned REG_AW_DEF       = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//   master : pipeline datapath (drives stage register info, consumes stall/flush/fwd)
//   slave  : hazard controller
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    // stage information from the datapath
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [REG_AW-1:0] write_reg_e, write_reg_m, write_reg_w;
    logic              uses_rs_d, uses_rt_d;
    logic              branch_d, jr_d, jump_d, pc_src_d;
    logic              syscall_d, syscall_halt;
    logic              reg_write_e, reg_write_m, reg_write_w;
    logic              mem_to_reg_e, mem_to_reg_m;
    // controls back to the datapath
    logic              stall_f, stall_d, flush_d, flush_e;
    logic [1:0]        fwd_a_e, fwd_b_e;
    logic              fwd_a_d, fwd_b_d;
    logic              syscall_go, halted;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               uses_rs_d, uses_rt_d, branch_d, jr_d, jump_d, pc_src_d,
               syscall_d, syscall_halt, reg_write_e, reg_write_m, reg_write_w,
               mem_to_reg_e, mem_to_reg_m,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
               fwd_a_d, fwd_b_d, syscall_go, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               uses_rs_d, uses_rt_d, branch_d, jr_d, jump_d, pc_src_d,
               syscall_d, syscall_halt, reg_write_e, reg_write_m, reg_write_w,
               mem_to_reg_e, mem_to_reg_m,
        output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
               fwd_a_d, fwd_b_d, syscall_go, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_syscall_drain_fsm.sv
// Syscall drain sequencer: on an accepted syscall, holds the front end for
// DRAIN_CYCLES so EX/MEM/WB retire, pulses syscall_go for one cycle, then
// returns to RUN or halts the core for an exit syscall.
//   clk, rst_n      : clock, async active-low reset
//   i_syscall_req   : syscall in ID accepted (RUN, no hazard stall)
//   i_syscall_halt  : syscall is exit, sampled with the request
//   o_state         : current sequencer state
//   o_syscall_go    : registered 1-cycle pulse while in EXEC
//   o_halted        : registered, set on entering HALT
module syscall_drain_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_syscall_req,
    input  logic         i_syscall_halt,
    output drain_state_e o_state,
    output logic         o_syscall_go,
    output logic         o_halted
);
    localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    drain_state_e r_state;
    logic [DW-1:0] r_cnt;
    logic          r_halt_pend;
    logic          r_go;
    logic          r_halted;

    // State, drain counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_halt_pend <= 1'b0;
            r_go        <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_go <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (i_syscall_req) begin
                        r_state     <= ST_DRAIN;
                        r_cnt       <= DW'(DRAIN_CYCLES);
                        r_halt_pend <= i_syscall_halt;
                    end
                end
                ST_DRAIN: begin
                    // leave on the last drain cycle so DRAIN lasts exactly DRAIN_CYCLES
                    if (r_cnt <= DW'(1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_EXEC;
                        r_go    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - DW'(1);
                    end
                end
                ST_EXEC: begin
                    r_state  <= r_halt_pend ? ST_HALT : ST_RUN;
                    r_halted <= r_halt_pend;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_syscall_go = r_go;
    assign o_halted     = r_halted;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline.
// Produces stall/flush for IF_ID and ID_EX, EX/ID forwarding selects,
// sequences syscalls through a drain FSM and keeps stall/flush statistics.
//   clk, rst_n : clock, async active-low reset
//   bus        : pipeline_hazard_ctrl_if.slave (stage info in, controls/stats out)
// Build option: PIPE_FORWARDING_EN enables forwarding (stall only on load-use
// and branch dependencies); without it every RAW dependency on EX/MEM stalls.
// stall/flush/fwd outputs are combinational so a hazard acts in the same cycle.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned REG_AW       = REG_AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    // $zero is never a real producer
    function automatic logic reg_hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    logic         w_rs_e, w_rt_e, w_rs_m, w_rt_m;
    logic         w_hazard;
    logic [1:0]   w_fwd_a_e, w_fwd_b_e;
    logic         w_fwd_a_d, w_fwd_b_d;
    drain_state_e w_state;
    logic         w_syscall_go, w_halted;
    logic         w_stall, w_flush_d, w_flush_e;
    logic         w_cnt_stall, w_cnt_flush;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // ID source matches against EX / MEM destinations, gated by operand use
    assign w_rs_e = bus.uses_rs_d & reg_hit(bus.rs_d, bus.write_reg_e);
    assign w_rt_e = bus.uses_rt_d & reg_hit(bus.rt_d, bus.write_reg_e);
    assign w_rs_m = bus.uses_rs_d & reg_hit(bus.rs_d, bus.write_reg_m);
    assign w_rt_m = bus.uses_rt_d & reg_hit(bus.rt_d, bus.write_reg_m);

`ifdef PIPE_FORWARDING_EN
    logic w_load_use, w_br_dep;
    assign w_load_use = bus.mem_to_reg_e & bus.reg_write_e & (w_rs_e | w_rt_e);
    assign w_br_dep   = (bus.branch_d | bus.jr_d) &
                        ((bus.reg_write_e & (w_rs_e | w_rt_e)) |
                         (bus.mem_to_reg_m & (w_rs_m | w_rt_m)));
    assign w_hazard   = w_load_use | w_br_dep;

    // MEM result is younger than WB, so it wins
    assign w_fwd_a_e = (bus.reg_write_m & reg_hit(bus.rs_e, bus.write_reg_m)) ? FWD_MEM :
                       (bus.reg_write_w & reg_hit(bus.rs_e, bus.write_reg_w)) ? FWD_WB : FWD_RF;
    assign w_fwd_b_e = (bus.reg_write_m & reg_hit(bus.rt_e, bus.write_reg_m)) ? FWD_MEM :
                       (bus.reg_write_w & reg_hit(bus.rt_e, bus.write_reg_w)) ? FWD_WB : FWD_RF;
    assign w_fwd_a_d = bus.reg_write_m & reg_hit(bus.rs_d, bus.write_reg_m);
    assign w_fwd_b_d = bus.reg_write_m & reg_hit(bus.rt_d, bus.write_reg_m);
`else
    logic w_unused_fwd_inputs;
    assign w_hazard  = (bus.reg_write_e & (w_rs_e | w_rt_e)) |
                       (bus.reg_write_m & (w_rs_m | w_rt_m));
    assign w_fwd_a_e = FWD_RF;
    assign w_fwd_b_e = FWD_RF;
    assign w_fwd_a_d = 1'b0;
    assign w_fwd_b_d = 1'b0;
    assign w_unused_fwd_inputs = ^{bus.rs_e, bus.rt_e, bus.write_reg_w, bus.reg_write_w,
                                   bus.mem_to_reg_e, bus.mem_to_reg_m, bus.branch_d};
`endif

    syscall_drain_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_syscall_req  (bus.syscall_d & ~w_hazard),
        .i_syscall_halt (bus.syscall_halt),
        .o_state        (w_state),
        .o_syscall_go   (w_syscall_go),
        .o_halted       (w_halted)
    );

    // Stall/flush by state: HALT > DRAIN/EXEC > hazard stall > branch flush
    always_comb begin
        w_stall   = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        case (w_state)
            ST_RUN: begin
                w_stall   = w_hazard;
                w_flush_e = w_hazard;
                w_flush_d = ~w_hazard & (bus.pc_src_d | bus.jump_d | bus.jr_d);
            end
            ST_DRAIN, ST_HALT: begin
                w_stall   = 1'b1;
                w_flush_e = 1'b1;
            end
            ST_EXEC: begin
                w_flush_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Combinational controls read 0 while reset is held
    assign bus.stall_f    = rst_n & w_stall;
    assign bus.stall_d    = rst_n & w_stall;
    assign bus.flush_e    = rst_n & w_flush_e;
    assign bus.flush_d    = rst_n & w_flush_d;
    assign bus.fwd_a_e    = rst_n ? w_fwd_a_e : FWD_RF;
    assign bus.fwd_b_e    = rst_n ? w_fwd_b_e : FWD_RF;
    assign bus.fwd_a_d    = rst_n & w_fwd_a_d;
    assign bus.fwd_b_d    = rst_n & w_fwd_b_d;
    assign bus.syscall_go = w_syscall_go;
    assign bus.halted     = w_halted;

    // Saturating statistics; frozen in HALT
    assign w_cnt_stall = w_stall & ((w_state == ST_RUN) | (w_state == ST_DRAIN));
    assign w_cnt_flush = w_flush_d & (w_state != ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_cnt_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_cnt_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard stall, forwarding,
// branch flush, syscall drain/exec/halt, async reset mid-drain.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.rs_d = '0; bus.rt_d = '0; bus.rs_e = '0; bus.rt_e = '0;
        bus.write_reg_e = '0; bus.write_reg_m = '0; bus.write_reg_w = '0;
        bus.uses_rs_d = 1'b0; bus.uses_rt_d = 1'b0;
        bus.branch_d = 1'b0; bus.jr_d = 1'b0; bus.jump_d = 1'b0; bus.pc_src_d = 1'b0;
        bus.syscall_d = 1'b0; bus.syscall_halt = 1'b0;
        bus.reg_write_e = 1'b0; bus.reg_write_m = 1'b0; bus.reg_write_w = 1'b0;
        bus.mem_to_reg_e = 1'b0; bus.mem_to_reg_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall_f"},   32'(bus.stall_f),    32'd0);
        chk({tag, "_stall_d"},   32'(bus.stall_d),    32'd0);
        chk({tag, "_flush_d"},   32'(bus.flush_d),    32'd0);
        chk({tag, "_flush_e"},   32'(bus.flush_e),    32'd0);
        chk({tag, "_go"},        32'(bus.syscall_go), 32'd0);
        chk({tag, "_halted"},    32'(bus.halted),     32'd0);
        chk({tag, "_stall_cnt"}, bus.stall_cnt,       32'd0);
        chk({tag, "_flush_cnt"}, bus.flush_cnt,       32'd0);
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        clr();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: load-use stall, one cycle
        tick();
        bus.write_reg_e = 5'd8; bus.mem_to_reg_e = 1'b1; bus.reg_write_e = 1'b1;
        bus.rs_d = 5'd8; bus.uses_rs_d = 1'b1;
        #2;
        chk("lu_stall_f", 32'(bus.stall_f), 32'd1);
        chk("lu_stall_d", 32'(bus.stall_d), 32'd1);
        chk("lu_flush_e", 32'(bus.flush_e), 32'd1);
        chk("lu_flush_d", 32'(bus.flush_d), 32'd0);
        chk("lu_cnt_before", bus.stall_cnt, 32'd0);
        tick();
        clr();
        #2;
        chk("lu_released", 32'(bus.stall_d), 32'd0);
        chk("lu_cnt_after", bus.stall_cnt, 32'd1);

        // 2: forwarding priority MEM over WB (combinational, cleared before the edge)
        tick();
        bus.rs_e = 5'd9; bus.rt_e = 5'd9;
        bus.write_reg_m = 5'd9; bus.reg_write_m = 1'b1;
        bus.write_reg_w = 5'd9; bus.reg_write_w = 1'b1;
        bus.rs_d = 5'd9; bus.uses_rs_d = 1'b1;
        #2;
`ifdef PIPE_FORWARDING_EN
        chk("fwd_a_e_mem", 32'(bus.fwd_a_e), 32'd2);
        chk("fwd_b_e_mem", 32'(bus.fwd_b_e), 32'd2);
        chk("fwd_a_d_mem", 32'(bus.fwd_a_d), 32'd1);
        chk("fwd_b_d_none", 32'(bus.fwd_b_d), 32'd0);
        chk("fwd_no_stall", 32'(bus.stall_d), 32'd0);
        bus.reg_write_m = 1'b0;
        #1;
        chk("fwd_a_e_wb", 32'(bus.fwd_a_e), 32'd1);
        chk("fwd_a_d_off", 32'(bus.fwd_a_d), 32'd0);
`else
        chk("nofwd_a_e", 32'(bus.fwd_a_e), 32'd0);
        chk("nofwd_a_d", 32'(bus.fwd_a_d), 32'd0);
        chk("nofwd_m_stall", 32'(bus.stall_d), 32'd1);
        bus.reg_write_m = 1'b0;
        #1;
        chk("nofwd_wb_nostall", 32'(bus.stall_d), 32'd0);
        chk("nofwd_b_e", 32'(bus.fwd_b_e), 32'd0);
`endif
        clr();

        // 3: register 0 never matches
        tick();
        bus.reg_write_e = 1'b1; bus.reg_write_m = 1'b1; bus.reg_write_w = 1'b1;
        bus.mem_to_reg_e = 1'b1; bus.uses_rs_d = 1'b1; bus.uses_rt_d = 1'b1;
        bus.branch_d = 1'b1;
        #2;
        chk("r0_stall", 32'(bus.stall_d), 32'd0);
        chk("r0_fwd_a_e", 32'(bus.fwd_a_e), 32'd0);
        chk("r0_fwd_b_e", 32'(bus.fwd_b_e), 32'd0);
        chk("r0_fwd_a_d", 32'(bus.fwd_a_d), 32'd0);
        chk("r0_fwd_b_d", 32'(bus.fwd_b_d), 32'd0);
        clr();

        // branch dependent on a load in MEM stalls in both builds
        bus.branch_d = 1'b1; bus.rt_d = 5'd7; bus.uses_rt_d = 1'b1;
        bus.write_reg_m = 5'd7; bus.mem_to_reg_m = 1'b1; bus.reg_write_m = 1'b1;
        #1;
        chk("brdep_m_stall", 32'(bus.stall_d), 32'd1);
        clr();

        // 4: taken branch flushes IF_ID
        tick();
        bus.pc_src_d = 1'b1;
        #2;
        chk("br_flush_d", 32'(bus.flush_d), 32'd1);
        chk("br_no_stall", 32'(bus.stall_d), 32'd0);
        tick();
        clr();
        #2;
        chk("br_flush_cnt", bus.flush_cnt, 32'd1);
        // taken branch with dependency on EX: stall wins, no flush
        bus.branch_d = 1'b1; bus.pc_src_d = 1'b1; bus.rs_d = 5'd5; bus.uses_rs_d = 1'b1;
        bus.write_reg_e = 5'd5; bus.reg_write_e = 1'b1;
        #1;
        chk("brdep_flush_d", 32'(bus.flush_d), 32'd0);
        chk("brdep_stall_d", 32'(bus.stall_d), 32'd1);
        chk("brdep_flush_e", 32'(bus.flush_e), 32'd1);
        tick();
        clr();
        #2;
        chk("brdep_stall_cnt", bus.stall_cnt, 32'd2);
        chk("brdep_flush_cnt", bus.flush_cnt, 32'd1);

        // syscall under a load-use stall is ignored
        bus.syscall_d = 1'b1;
        bus.write_reg_e = 5'd3; bus.mem_to_reg_e = 1'b1; bus.reg_write_e = 1'b1;
        bus.rs_d = 5'd3; bus.uses_rs_d = 1'b1;
        tick();
        clr();
        #2;
        chk("sys_ignored_run", 32'(bus.stall_d), 32'd0);
        chk("sys_ignored_cnt", bus.stall_cnt, 32'd3);

        // 5: syscall, non-exit: 3 drain cycles, go on the 4th, back to RUN
        bus.syscall_d = 1'b1;
        #1;
        chk("sys_accept_nostall", 32'(bus.stall_d), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("drain_stall_f", 32'(bus.stall_f), 32'd1);
            chk("drain_flush_e", 32'(bus.flush_e), 32'd1);
            chk("drain_go", 32'(bus.syscall_go), 32'd0);
        end
        tick();
        clr();
        #2;
        chk("exec_go", 32'(bus.syscall_go), 32'd1);
        chk("exec_flush_d", 32'(bus.flush_d), 32'd1);
        chk("exec_stall_f", 32'(bus.stall_f), 32'd0);
        tick();
        #2;
        chk("run_go", 32'(bus.syscall_go), 32'd0);
        chk("run_halted", 32'(bus.halted), 32'd0);
        chk("sys_stall_cnt", bus.stall_cnt, 32'd6);
        chk("sys_flush_cnt", bus.flush_cnt, 32'd2);

        // exit syscall halts the core and freezes statistics
        bus.syscall_d = 1'b1; bus.syscall_halt = 1'b1;
        tick(); tick(); tick();
        tick();
        #2;
        chk("exit_exec_go", 32'(bus.syscall_go), 32'd1);
        chk("exit_exec_halted", 32'(bus.halted), 32'd0);
        clr();
        tick();
        #2;
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_stall_f", 32'(bus.stall_f), 32'd1);
        chk("halt_flush_e", 32'(bus.flush_e), 32'd1);
        chk("halt_stall_cnt", bus.stall_cnt, 32'd9);
        chk("halt_flush_cnt", bus.flush_cnt, 32'd3);
        bus.pc_src_d = 1'b1; bus.syscall_d = 1'b1;
        tick(); tick();
        #2;
        chk("halt_held", 32'(bus.halted), 32'd1);
        chk("halt_flush_d", 32'(bus.flush_d), 32'd0);
        chk("halt_go", 32'(bus.syscall_go), 32'd0);
        chk("halt_stall_frozen", bus.stall_cnt, 32'd9);
        chk("halt_flush_frozen", bus.flush_cnt, 32'd3);

        // reset out of HALT without a clock edge
        rst_n = 1'b0;
        clr();
        #1;
        chk_all_zero("rst_halt");
        rst_n = 1'b1;

        // 6: reset during drain cycle 2
        tick();
        bus.syscall_d = 1'b1;
        tick();
        tick();
        #2;
        chk("d2_stall_d", 32'(bus.stall_d), 32'd1);
        chk("d2_stall_cnt", bus.stall_cnt, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_drain");
        clr();
        #1;
        rst_n = 1'b1;
        tick();
        #2;
        chk("post_rst_stall", 32'(bus.stall_d), 32'd0);
        tick(); tick(); tick();
        #2;
        chk("post_rst_go", 32'(bus.syscall_go), 32'd0);
        chk("post_rst_stall_late", 32'(bus.stall_d), 32'd0);
        chk("post_rst_cnt", bus.stall_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
